addsub_arbiter: RTL

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_pkg.sv | 11 +
 rtl/addsub_arbiter_if.sv | 45 ++++
 rtl/addsub_unit.sv | 31 +++
 rtl/addsub_arbiter.sv | 131 +++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared constants and types for the two-requester add/sub pipeline.
package addsub_pkg;

   localparam int unsigned W_DEFAULT = 8;
   localparam logic        OP_ADD    = 1'b0;
   localparam logic        OP_SUB    = 1'b1;
   localparam int unsigned ID_W      = 1;

   typedef logic [ID_W-1:0] id_t;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Requester and result-consumer signals of addsub_arbiter, grouped as one bus.
interface addsub_arbiter_if
   import addsub_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
);

   logic         req0;
   logic [W-1:0] a0;
   logic [W-1:0] b0;
   logic         sel0;
   logic         gnt0;

   logic         req1;
   logic [W-1:0] a1;
   logic [W-1:0] b1;
   logic         sel1;
   logic         gnt1;

   logic         res_valid;
   logic         res_ready;
   id_t          res_id;
   logic [W-1:0] res_s;
   logic         res_cout;
   logic         res_ovf;

   modport master (
      output req0, a0, b0, sel0,
      input  gnt0,
      output req1, a1, b1, sel1,
      input  gnt1,
      input  res_valid, res_id, res_s, res_cout, res_ovf,
      output res_ready
   );

   modport slave (
      input  req0, a0, b0, sel0,
      output gnt0,
      input  req1, a1, b1, sel1,
      output gnt1,
      output res_valid, res_id, res_s, res_cout, res_ovf,
      input  res_ready
   );

endinterface

// File: rtl/addsub_unit.sv
// Combinational W-bit ripple-carry adder/subtractor with carry-out and signed overflow.
module addsub_unit
   import addsub_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] s,
   output logic         cout,
   output logic         ovf
);

   logic [W-1:0] b_x;
   logic         c;

   always_comb begin
      // Subtract is a + ~b + 1: sel inverts b and seeds the carry chain.
      b_x = b ^ {W{sel}};
      c   = sel;
      s   = '0;
      for (int i = 0; i < W; i++) begin
         s[i] = a[i] ^ b_x[i] ^ c;
         c    = (a[i] & b_x[i]) | (c & (a[i] ^ b_x[i]));
      end
      cout = c;
      ovf  = (a[W-1] == b_x[W-1]) && (s[W-1] != a[W-1]);
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter feeding a shared add/sub unit through a
// two-stage (operand, result) pipeline with valid/ready backpressure on the result.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int unsigned W = W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   addsub_arbiter_if.slave   bus
);

   logic         s1_v_q, s1_v_d;
   logic [W-1:0] s1_a_q, s1_a_d;
   logic [W-1:0] s1_b_q, s1_b_d;
   logic         s1_sel_q, s1_sel_d;
   id_t          s1_id_q, s1_id_d;
   id_t          last_q, last_d;

   logic         res_valid_q, res_valid_d;
   logic [W-1:0] res_s_q, res_s_d;
   logic         res_cout_q, res_cout_d;
   logic         res_ovf_q, res_ovf_d;
   id_t          res_id_q, res_id_d;

   logic         s2_load;
   logic         s1_free;
   logic         gnt0;
   logic         gnt1;
   logic [W-1:0] u_s;
   logic         u_cout;
   logic         u_ovf;

   addsub_unit #(
      .W(W)
   ) u_addsub_unit (
      .a    (s1_a_q),
      .b    (s1_b_q),
      .sel  (s1_sel_q),
      .s    (u_s),
      .cout (u_cout),
      .ovf  (u_ovf)
   );

   // On a tie the requester that was not granted last wins.
   always_comb begin
      s2_load = !res_valid_q || bus.res_ready;
      s1_free = !s1_v_q || s2_load;
      gnt0    = !rst && s1_free && bus.req0 && (!bus.req1 || (last_q == id_t'(1)));
      gnt1    = !rst && s1_free && bus.req1 && (!bus.req0 || (last_q == id_t'(0)));
   end

   always_comb begin
      s1_v_d      = s1_v_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      s1_sel_d    = s1_sel_q;
      s1_id_d     = s1_id_q;
      last_d      = last_q;
      res_valid_d = res_valid_q;
      res_s_d     = res_s_q;
      res_cout_d  = res_cout_q;
      res_ovf_d   = res_ovf_q;
      res_id_d    = res_id_q;

      if (s2_load) begin
         res_valid_d = s1_v_q;
         if (s1_v_q) begin
            res_s_d    = u_s;
            res_cout_d = u_cout;
            res_ovf_d  = u_ovf;
            res_id_d   = s1_id_q;
         end
      end

      if (s1_free) begin
         s1_v_d = gnt0 || gnt1;
         if (gnt0) begin
            s1_a_d   = bus.a0;
            s1_b_d   = bus.b0;
            s1_sel_d = bus.sel0;
            s1_id_d  = id_t'(0);
            last_d   = id_t'(0);
         end else if (gnt1) begin
            s1_a_d   = bus.a1;
            s1_b_d   = bus.b1;
            s1_sel_d = bus.sel1;
            s1_id_d  = id_t'(1);
            last_d   = id_t'(1);
         end
      end
   end

   // Pointer resets to requester 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_v_q      <= 1'b0;
         s1_a_q      <= '0;
         s1_b_q      <= '0;
         s1_sel_q    <= OP_ADD;
         s1_id_q     <= id_t'(0);
         last_q      <= id_t'(1);
         res_valid_q <= 1'b0;
         res_s_q     <= '0;
         res_cout_q  <= 1'b0;
         res_ovf_q   <= 1'b0;
         res_id_q    <= id_t'(0);
      end else begin
         s1_v_q      <= s1_v_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         s1_sel_q    <= s1_sel_d;
         s1_id_q     <= s1_id_d;
         last_q      <= last_d;
         res_valid_q <= res_valid_d;
         res_s_q     <= res_s_d;
         res_cout_q  <= res_cout_d;
         res_ovf_q   <= res_ovf_d;
         res_id_q    <= res_id_d;
      end
   end

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.res_valid = res_valid_q;
   assign bus.res_s     = res_s_q;
   assign bus.res_cout  = res_cout_q;
   assign bus.res_ovf   = res_ovf_q;
   assign bus.res_id    = res_id_q;

endmodule
